// File: rtl/load_store_queue_if.sv
// Signal bundle for load_store_queue: dispatch, wakeup buses, flush, dcache port, load result bus.
// LSQ_MISALIGN_TRAP_EN adds ld_bcast_exc.
interface load_store_queue_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ROB_ID_W = 5
);
  logic                  dispatch_ready;
  logic                  dispatch_valid;
  logic                  dispatch_is_store;
  logic [2:0]            dispatch_funct3;
  logic [ROB_ID_W-1:0]   dispatch_rob_id;
  logic [11:0]           dispatch_imm;
  logic [1:0]            dispatch_src_ready;
  logic [2*ROB_ID_W-1:0] dispatch_src_tag;
  logic [2*XLEN-1:0]     dispatch_src_val;
  logic                  alu_broadcast_valid;
  logic [ROB_ID_W-1:0]   alu_broadcast_rob_id;
  logic [XLEN-1:0]       alu_broadcast_reg_data;
  logic                  flush;
  logic                  dc_req_valid;
  logic                  dc_req_we;
  logic                  dc_req_ready;
  logic [XLEN-1:0]       dc_req_addr;
  logic [XLEN-1:0]       dc_req_wdata;
  logic [2:0]            dc_req_funct3;
  logic                  dc_resp_valid;
  logic [XLEN-1:0]       dc_resp_data;
  logic                  ld_bcast_valid;
  logic [ROB_ID_W-1:0]   ld_bcast_rob_id;
  logic [XLEN-1:0]       ld_bcast_data;
`ifdef LSQ_MISALIGN_TRAP_EN
  logic                  ld_bcast_exc;
`endif

  modport slave (
`ifdef LSQ_MISALIGN_TRAP_EN
    output ld_bcast_exc,
`endif
    output dispatch_ready,
    input  dispatch_valid, dispatch_is_store, dispatch_funct3, dispatch_rob_id,
    input  dispatch_imm, dispatch_src_ready, dispatch_src_tag, dispatch_src_val,
    input  alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
    input  flush,
    output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_funct3,
    input  dc_req_ready, dc_resp_valid, dc_resp_data,
    output ld_bcast_valid, ld_bcast_rob_id, ld_bcast_data
  );

  modport master (
`ifdef LSQ_MISALIGN_TRAP_EN
    input  ld_bcast_exc,
`endif
    input  dispatch_ready,
    output dispatch_valid, dispatch_is_store, dispatch_funct3, dispatch_rob_id,
    output dispatch_imm, dispatch_src_ready, dispatch_src_tag, dispatch_src_val,
    output alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
    output flush,
    input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_funct3,
    output dc_req_ready, dc_resp_valid, dc_resp_data,
    input  ld_bcast_valid, ld_bcast_rob_id, ld_bcast_data
  );
endinterface

// File: rtl/load_store_queue.sv
// In-order load/store queue: circular buffer with operand wakeup, single dcache port, load result bus.
// Define LSQ_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of sending them to the dcache.
module load_store_queue #(
  parameter int unsigned LSQ_DEPTH = 8,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_ID_W  = 5
) (
  input logic               clk,
  input logic               rst_aL,
  load_store_queue_if.slave lsq
);
  localparam int unsigned PTR_W = $clog2(LSQ_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state_q, state_d;

  logic [PTR_W:0]   head_q, tail_q;
  logic [PTR_W-1:0] h_idx, t_idx;
  logic             empty, full, push, pop, resp_fire, trap_fire;

  logic [LSQ_DEPTH-1:0] e_store;
  logic [2:0]           e_funct3 [LSQ_DEPTH];
  logic [ROB_ID_W-1:0]  e_rob    [LSQ_DEPTH];
  logic [11:0]          e_imm    [LSQ_DEPTH];
  logic [1:0]           e_rdy    [LSQ_DEPTH];
  logic [ROB_ID_W-1:0]  e_tag    [LSQ_DEPTH][2];
  logic [XLEN-1:0]      e_val    [LSQ_DEPTH][2];

  logic [1:0]          d_rdy;
  logic [ROB_ID_W-1:0] d_tag [2];
  logic [XLEN-1:0]     d_val [2];

  logic                ldb_valid_q;
  logic [ROB_ID_W-1:0] ldb_rob_q;
  logic [XLEN-1:0]     ldb_data_q;

  logic            h_store, h_eligible, byp_eligible, h_misaligned, req_valid;
  logic [2:0]      h_f3;
  logic [1:0]      h_rdy;
  logic [XLEN-1:0] h_addr, h_sdata, resp_shift, ld_ext;

  assign h_idx = head_q[PTR_W-1:0];
  assign t_idx = tail_q[PTR_W-1:0];
  assign empty = (head_q == tail_q);
  assign full  = (h_idx == t_idx) && (head_q[PTR_W] != tail_q[PTR_W]);
  assign push  = lsq.dispatch_valid && !full && !lsq.flush;

  // Incoming operands see this cycle's broadcasts so nothing is missed between dispatch and write.
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      d_tag[s] = lsq.dispatch_src_tag[s*ROB_ID_W +: ROB_ID_W];
      d_val[s] = lsq.dispatch_src_val[s*XLEN +: XLEN];
      d_rdy[s] = lsq.dispatch_src_ready[s];
      if (!lsq.dispatch_src_ready[s]) begin
        if (lsq.alu_broadcast_valid && lsq.alu_broadcast_rob_id == d_tag[s]) begin
          d_rdy[s] = 1'b1;
          d_val[s] = lsq.alu_broadcast_reg_data;
        end else if (ldb_valid_q && ldb_rob_q == d_tag[s]) begin
          d_rdy[s] = 1'b1;
          d_val[s] = ldb_data_q;
        end
      end
    end
  end

  assign h_store = e_store[h_idx];
  assign h_f3    = e_funct3[h_idx];
  assign h_rdy   = e_rdy[h_idx];
  assign h_sdata = e_val[h_idx][1];
  assign h_addr  = e_val[h_idx][0] + {{(XLEN-12){e_imm[h_idx][11]}}, e_imm[h_idx]};

  assign h_eligible   = !empty && h_rdy[0] && (!h_store || h_rdy[1]);
  assign byp_eligible = empty && push && d_rdy[0] && (!lsq.dispatch_is_store || d_rdy[1]);

`ifdef LSQ_MISALIGN_TRAP_EN
  assign h_misaligned = (h_f3[1:0] == 2'b01 && h_addr[0]) ||
                        (h_f3[1:0] == 2'b10 && h_addr[1:0] != 2'b00);
`else
  assign h_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Bypass from an empty queue lets a ready op reach REQ on the same edge it is written.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    resp_fire = 1'b0;
    trap_fire = 1'b0;
    case (state_q)
      IDLE: if (h_eligible || byp_eligible) state_d = REQ;
      REQ: begin
        if (h_misaligned) begin
          pop       = 1'b1;
          trap_fire = 1'b1;
          state_d   = IDLE;
        end else if (lsq.dc_req_ready) begin
          pop     = h_store;
          state_d = h_store ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (lsq.dc_resp_valid) begin
          pop       = 1'b1;
          resp_fire = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (lsq.flush) begin
      state_d   = IDLE;
      pop       = 1'b0;
      resp_fire = 1'b0;
      trap_fire = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (lsq.flush) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (pop)  head_q <= head_q + 1'b1;
      if (push) tail_q <= tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      e_store <= '0;
      for (int unsigned i = 0; i < LSQ_DEPTH; i++) begin
        e_funct3[i] <= '0;
        e_rob[i]    <= '0;
        e_imm[i]    <= '0;
        e_rdy[i]    <= '0;
        for (int unsigned s = 0; s < 2; s++) begin
          e_tag[i][s] <= '0;
          e_val[i][s] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < LSQ_DEPTH; i++) begin
        for (int unsigned s = 0; s < 2; s++) begin
          if (!e_rdy[i][s]) begin
            if (lsq.alu_broadcast_valid && lsq.alu_broadcast_rob_id == e_tag[i][s]) begin
              e_rdy[i][s] <= 1'b1;
              e_val[i][s] <= lsq.alu_broadcast_reg_data;
            end else if (ldb_valid_q && ldb_rob_q == e_tag[i][s]) begin
              e_rdy[i][s] <= 1'b1;
              e_val[i][s] <= ldb_data_q;
            end
          end
        end
      end
      if (push) begin
        e_store[t_idx]  <= lsq.dispatch_is_store;
        e_funct3[t_idx] <= lsq.dispatch_funct3;
        e_rob[t_idx]    <= lsq.dispatch_rob_id;
        e_imm[t_idx]    <= lsq.dispatch_imm;
        e_rdy[t_idx]    <= d_rdy;
        e_tag[t_idx][0] <= d_tag[0];
        e_tag[t_idx][1] <= d_tag[1];
        e_val[t_idx][0] <= d_val[0];
        e_val[t_idx][1] <= d_val[1];
      end
    end
  end

  always_comb begin
    resp_shift = lsq.dc_resp_data >> {h_addr[1:0], 3'b000};
    case (h_f3)
      3'b000:  ld_ext = {{(XLEN-8){resp_shift[7]}}, resp_shift[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){resp_shift[15]}}, resp_shift[15:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, resp_shift[7:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, resp_shift[15:0]};
      default: ld_ext = lsq.dc_resp_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      ldb_valid_q <= 1'b0;
      ldb_rob_q   <= '0;
      ldb_data_q  <= '0;
    end else begin
      ldb_valid_q <= resp_fire || trap_fire;
      if (resp_fire || trap_fire) begin
        ldb_rob_q  <= e_rob[h_idx];
        ldb_data_q <= trap_fire ? '0 : ld_ext;
      end
    end
  end

`ifdef LSQ_MISALIGN_TRAP_EN
  logic ldb_exc_q;
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) ldb_exc_q <= 1'b0;
    else         ldb_exc_q <= trap_fire;
  end
  assign lsq.ld_bcast_exc = ldb_exc_q;
`endif

  assign req_valid          = (state_q == REQ) && !h_misaligned;
  assign lsq.dispatch_ready = !full;
  assign lsq.dc_req_valid   = req_valid;
  assign lsq.dc_req_we      = req_valid && h_store;
  assign lsq.dc_req_addr    = req_valid ? h_addr : '0;
  assign lsq.dc_req_wdata   = (req_valid && h_store) ? h_sdata : '0;
  assign lsq.dc_req_funct3  = req_valid ? h_f3 : '0;
  assign lsq.ld_bcast_valid  = ldb_valid_q;
  assign lsq.ld_bcast_rob_id = ldb_rob_q;
  assign lsq.ld_bcast_data   = ldb_data_q;
endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue (default build, misalign trap disabled).
module tb_load_store_queue;
  logic        clk = 1'b0;
  logic        rst_aL;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  load_store_queue_if #(.XLEN(32), .ROB_ID_W(5)) bus ();

  load_store_queue #(.LSQ_DEPTH(8), .XLEN(32), .ROB_ID_W(5)) dut (
    .clk   (clk),
    .rst_aL(rst_aL),
    .lsq   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dispatch(input logic st, input logic [2:0] f3, input logic [4:0] rob,
                          input logic [11:0] imm, input logic [1:0] rdy,
                          input logic [4:0] tag0, input logic [4:0] tag1,
                          input logic [31:0] v0, input logic [31:0] v1);
    bus.dispatch_valid     = 1'b1;
    bus.dispatch_is_store  = st;
    bus.dispatch_funct3    = f3;
    bus.dispatch_rob_id    = rob;
    bus.dispatch_imm       = imm;
    bus.dispatch_src_ready = rdy;
    bus.dispatch_src_tag   = {tag1, tag0};
    bus.dispatch_src_val   = {v1, v0};
    tick();
    bus.dispatch_valid     = 1'b0;
  endtask

  // Full load: dispatch into empty queue, request next cycle, accept, respond, check result bus.
  task automatic load_txn(input string tag, input logic [2:0] f3, input logic [4:0] rob,
                          input logic [31:0] base, input logic [11:0] imm,
                          input logic [31:0] exp_addr, input logic [31:0] resp,
                          input logic [31:0] exp_data);
    bus.dc_req_ready = 1'b1;
    dispatch(1'b0, f3, rob, imm, 2'b01, 5'd0, 5'd0, base, 32'h0);
    chk({tag, "_req_valid"}, bus.dc_req_valid, 1);
    chk({tag, "_req_addr"}, bus.dc_req_addr, exp_addr);
    chk({tag, "_req_we"}, bus.dc_req_we, 0);
    chk({tag, "_req_f3"}, bus.dc_req_funct3, f3);
    tick();
    chk({tag, "_wait_noreq"}, bus.dc_req_valid, 0);
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_data  = resp;
    tick();
    bus.dc_resp_valid = 1'b0;
    chk({tag, "_bcast_valid"}, bus.ld_bcast_valid, 1);
    chk({tag, "_bcast_data"}, bus.ld_bcast_data, exp_data);
    chk({tag, "_bcast_rob"}, bus.ld_bcast_rob_id, rob);
    tick();
    chk({tag, "_bcast_once"}, bus.ld_bcast_valid, 0);
  endtask

  initial begin
    rst_aL                     = 1'b0;
    bus.dispatch_valid         = 1'b0;
    bus.dispatch_is_store      = 1'b0;
    bus.dispatch_funct3        = 3'b000;
    bus.dispatch_rob_id        = '0;
    bus.dispatch_imm           = '0;
    bus.dispatch_src_ready     = '0;
    bus.dispatch_src_tag       = '0;
    bus.dispatch_src_val       = '0;
    bus.alu_broadcast_valid    = 1'b0;
    bus.alu_broadcast_rob_id   = '0;
    bus.alu_broadcast_reg_data = '0;
    bus.flush                  = 1'b0;
    bus.dc_req_ready           = 1'b0;
    bus.dc_resp_valid          = 1'b0;
    bus.dc_resp_data           = '0;

    #12;
    chk("rst_dispatch_ready", bus.dispatch_ready, 1);
    chk("rst_req_valid", bus.dc_req_valid, 0);
    chk("rst_bcast_valid", bus.ld_bcast_valid, 0);
    chk("rst_req_addr", bus.dc_req_addr, 32'h0);
    chk("rst_bcast_data", bus.ld_bcast_data, 32'h0);
    @(negedge clk);
    rst_aL = 1'b1;
    tick();

    load_txn("lw", 3'b010, 5'd1, 32'h100, 12'd4, 32'h104, 32'hDEADBEEF, 32'hDEADBEEF);
    load_txn("lb", 3'b000, 5'd2, 32'h100, 12'd3, 32'h103, 32'h80FFFFFF, 32'hFFFFFF80);
    load_txn("lbu", 3'b100, 5'd3, 32'h100, 12'd3, 32'h103, 32'h80FFFFFF, 32'h00000080);
    load_txn("lhu", 3'b101, 5'd5, 32'h100, 12'd2, 32'h102, 32'hABCD1234, 32'h0000ABCD);
    load_txn("wrap", 3'b100, 5'd10, 32'hFFFFFFFE, 12'd4, 32'h00000002, 32'h00AB0000, 32'h000000AB);

    // Base operand woken by ALU broadcast in the dispatch cycle; negative offset.
    bus.dc_req_ready           = 1'b1;
    bus.alu_broadcast_valid    = 1'b1;
    bus.alu_broadcast_rob_id   = 5'd7;
    bus.alu_broadcast_reg_data = 32'h500;
    dispatch(1'b0, 3'b010, 5'd9, 12'hFFC, 2'b00, 5'd7, 5'd0, 32'h0, 32'h0);
    bus.alu_broadcast_valid    = 1'b0;
    chk("bypwake_req_valid", bus.dc_req_valid, 1);
    chk("bypwake_req_addr", bus.dc_req_addr, 32'h4FC);
    tick();
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_data  = 32'h11223344;
    tick();
    bus.dc_resp_valid = 1'b0;
    chk("bypwake_bcast_data", bus.ld_bcast_data, 32'h11223344);
    tick();

    // Store whose data tag 3 arrives later on the ALU bus.
    dispatch(1'b1, 3'b010, 5'd4, 12'd0, 2'b01, 5'd0, 5'd3, 32'h200, 32'h0);
    chk("sw_blocked", bus.dc_req_valid, 0);
    bus.alu_broadcast_valid    = 1'b1;
    bus.alu_broadcast_rob_id   = 5'd3;
    bus.alu_broadcast_reg_data = 32'h55;
    tick();
    bus.alu_broadcast_valid    = 1'b0;
    chk("sw_idle_after_wake", bus.dc_req_valid, 0);
    tick();
    chk("sw_req_valid", bus.dc_req_valid, 1);
    chk("sw_req_we", bus.dc_req_we, 1);
    chk("sw_req_wdata", bus.dc_req_wdata, 32'h55);
    chk("sw_req_addr", bus.dc_req_addr, 32'h200);
    tick();
    chk("sw_retired", bus.dc_req_valid, 0);
    chk("sw_no_bcast", bus.ld_bcast_valid, 0);

    // Fill all 8 entries with the dcache stalled.
    bus.dc_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dispatch(1'b1, 3'b010, 5'(8 + i), 12'd0, 2'b11, 5'd0, 5'd0, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i));
      chk($sformatf("fill_ready_%0d", i), bus.dispatch_ready, (i < 7) ? 1 : 0);
    end
    chk("full_head_addr", bus.dc_req_addr, 32'h300);
    chk("full_head_wdata", bus.dc_req_wdata, 32'h1000);
    bus.dc_req_ready = 1'b1;
    #1;
    chk("full_same_cycle_free", bus.dispatch_ready, 0);
    tick();
    chk("full_after_retire", bus.dispatch_ready, 1);
    bus.dc_req_ready = 1'b0;
    bus.flush        = 1'b1;
    tick();
    bus.flush        = 1'b0;
    chk("flush_full_noreq", bus.dc_req_valid, 0);
    chk("flush_full_ready", bus.dispatch_ready, 1);

    // Flush while waiting for a load response; late response must be dropped.
    bus.dc_req_ready = 1'b1;
    dispatch(1'b0, 3'b010, 5'd12, 12'd0, 2'b01, 5'd0, 5'd0, 32'h400, 32'h0);
    chk("fw_req_valid", bus.dc_req_valid, 1);
    tick();
    chk("fw_in_wait", bus.dc_req_valid, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fw_ready", bus.dispatch_ready, 1);
    chk("fw_noreq", bus.dc_req_valid, 0);
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_data  = 32'h12345678;
    tick();
    bus.dc_resp_valid = 1'b0;
    chk("fw_drop_resp", bus.ld_bcast_valid, 0);
    tick();
    chk("fw_drop_resp2", bus.ld_bcast_valid, 0);

    load_txn("lh_after_flush", 3'b001, 5'd13, 32'h500, 12'd2, 32'h502, 32'hABCD1234, 32'hFFFFABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter LSQ_DEPTH, default 8, queue entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, data/address width.
REQ-003 SHALL have parameter ROB_ID_W, default 5, ROB tag width.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_aL  in  1  asynchronous active-low reset.
REQ-006 SHALL have port dispatch_ready  out  1  queue can accept an op.
REQ-007 SHALL have port dispatch_valid  in  1  op offered.
REQ-008 SHALL have port dispatch_is_store  in  1  1=store, 0=load.
REQ-009 SHALL have port dispatch_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port dispatch_rob_id  in  ROB_ID_W  op tag.
REQ-011 SHALL have port dispatch_imm  in  12  signed address offset.
REQ-012 SHALL have port dispatch_src_ready  in  2  bit0 base ready, bit1 store-data ready.
REQ-013 SHALL have port dispatch_src_tag  in  2*ROB_ID_W  producer tags, src0 in LSBs.
REQ-014 SHALL have port dispatch_src_val  in  2*XLEN  operand values, src0 in LSBs.
REQ-015 SHALL have ports alu_broadcast_valid/alu_broadcast_rob_id/alu_broadcast_reg_data  in  1/ROB_ID_W/XLEN  ALU result bus.
REQ-016 SHALL have port flush  in  1  discard all entries.
REQ-017 SHALL have ports dc_req_valid/dc_req_we  out  1/1  dcache request, write enable.
REQ-018 SHALL have port dc_req_ready  in  1  dcache accepts request.
REQ-019 SHALL have ports dc_req_addr/dc_req_wdata  out  XLEN/XLEN  address, store data.
REQ-020 SHALL have port dc_req_funct3  out  3  access size/signedness.
REQ-021 SHALL have ports dc_resp_valid/dc_resp_data  in  1/XLEN  load data return, raw aligned word.
REQ-022 SHALL have ports ld_bcast_valid/ld_bcast_rob_id/ld_bcast_data  out  1/ROB_ID_W/XLEN  load result bus.

Function
REQ-023 SHALL be a circular buffer with head/tail pointers plus wrap bit; dispatch_ready=0 iff full; allocate at tail on dispatch_valid&dispatch_ready.
REQ-024 SHALL, each cycle, set any not-ready source whose tag matches a valid alu_broadcast or ld_bcast to ready with the broadcast value, including an op dispatched that same cycle.
REQ-025 SHALL issue strictly in order from head only; head eligible when base ready and (load, or store-data ready).
REQ-026 SHALL compute dc_req_addr = base + sign-extended imm, modulo 2^XLEN.
REQ-027 SHALL use FSM IDLE->REQ when head eligible; REQ holds dc_req_valid with stable payload until dc_req_ready; store: free head, ->IDLE; load: ->WAIT; WAIT: on dc_resp_valid free head, ->IDLE.
REQ-028 SHALL assert dc_req_valid the cycle after an eligible op is written into an empty queue (latency 1).
REQ-029 SHALL drive ld_bcast_valid for exactly one cycle, the cycle after dc_resp_valid, with byte/half extracted by addr[1:0] and sign- or zero-extended per funct3.
REQ-030 SHALL compute dispatch_ready from registered occupancy; a free in the same cycle does not raise it while full.
REQ-031 SHALL, on flush, empty the queue and return the FSM to IDLE next cycle; flush beats dispatch; a pending load response arriving after flush is dropped, no ld_bcast.

Reset
REQ-032 SHALL on rst_aL low immediately clear pointers, entries, FSM=IDLE; outputs dispatch_ready=1, dc_req_valid=0, ld_bcast_valid=0, other outputs 0; reset mid-transaction abandons it.

Configuration
REQ-033 SHALL with LSQ_MISALIGN_TRAP_EN defined add output ld_bcast_exc (1); misaligned H/W ops skip dcache, free head, pulse ld_bcast_valid with ld_bcast_exc=1, data 0.
REQ-034 SHALL without LSQ_MISALIGN_TRAP_EN omit the port and send misaligned ops to dcache unchanged.

Verification
REQ-035 SHALL test LW, base 0x100 ready, imm 4, dc_resp 0xDEADBEEF -> addr 0x104, ld_bcast_data 0xDEADBEEF one cycle after response.
REQ-036 SHALL test LB addr 0x103, resp 0x80FFFFFF -> ld_bcast_data 0xFFFFFF80; LBU -> 0x00000080.
REQ-037 SHALL test SW, data tag 3 not ready, ALU broadcast tag 3 value 0x55 -> dc_req_we=1, wdata 0x55 after broadcast.
REQ-038 SHALL test 8 dispatches with dc_req_ready=0 -> dispatch_ready=0 after 8th; one store retire -> ready=1 next cycle.
REQ-039 SHALL test flush while in WAIT -> queue empty, subsequent dc_resp_valid gives no ld_bcast_valid.
